// File: rtl/f_pc_unit_pkg.sv
// Shared definitions for the fetch-stage PC unit.
//  - NPC_SEL encodings driven by the decoder in D
//  - reset and exception-entry addresses
//  - branch-offset helper
package f_pc_unit_pkg;

  // Next-PC select codes coming from D; unused codes fall back to sequential.
  localparam logic [2:0] NPC_SEQ = 3'b000;
  localparam logic [2:0] NPC_J   = 3'b001;
  localparam logic [2:0] NPC_BR  = 3'b010;
  localparam logic [2:0] NPC_JR  = 3'b011;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_PC   = 32'h0000_4180;

  // Sign-extended, word-scaled branch displacement.
  function automatic logic [31:0] br_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/f_pc_unit_if.sv
// Port bundle between the pipeline control (master) and the fetch PC unit
// (slave). The master drives stall/redirect requests and decode-stage
// operands; the slave returns the fetch PC, next PC, address-error flag and
// the return-address-stack status and statistics.
interface f_pc_unit_if #(
  parameter int CNT_W = 16
);
  logic             stall;
  logic             exc_req;
  logic             eret_req;
  logic [31:0]      epc;
  logic [2:0]       npc_sel;
  logic [31:0]      pc4_d;
  logic [15:0]      i16;
  logic [25:0]      i26;
  logic             b_jump;
  logic [31:0]      rs_d;
  logic             call_d;
  logic             ret_d;
  logic [31:0]      pc_f;
  logic [31:0]      npc;
  logic             pc_adel_f;
  logic [31:0]      ras_top;
  logic             ras_empty;
  logic [CNT_W-1:0] ras_hit;
  logic [CNT_W-1:0] ras_miss;

  modport master (
    output stall, exc_req, eret_req, epc, npc_sel, pc4_d, i16, i26,
           b_jump, rs_d, call_d, ret_d,
    input  pc_f, npc, pc_adel_f, ras_top, ras_empty, ras_hit, ras_miss
  );

  modport slave (
    input  stall, exc_req, eret_req, epc, npc_sel, pc4_d, i16, i26,
           b_jump, rs_d, call_d, ret_d,
    output pc_f, npc, pc_adel_f, ras_top, ras_empty, ras_hit, ras_miss
  );
endinterface

// File: rtl/f_pc_unit_ras_stack.sv
// ras_stack: circular return-address LIFO.
// Ports:
//  clk, rst    clock, asynchronous active-high reset (empties the stack)
//  push        write push_data on top
//  pop         remove the top entry (ignored when empty)
//  push_data   value to push
//  top         current top entry, 0 when empty
//  count       number of valid entries (0..DEPTH)
// Push on a full stack overwrites the oldest entry. Push and pop together on
// a non-empty stack replace the top in place; on an empty stack it is a push.
module f_pc_unit_ras_stack
  import f_pc_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [31:0]                push_data,
  output logic [31:0]                top,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]   mem_r [DEPTH];
  logic [PW-1:0] ptr_r;
  logic [CW-1:0] count_r;
  logic [PW-1:0] top_idx_s;
  logic          nonempty_s;
  logic          replace_s;

  // ptr points at the next free slot; the top lives one below it (wrapping).
  assign top_idx_s  = ptr_r - PW'(1'b1);
  assign nonempty_s = (count_r != {CW{1'b0}});
  assign replace_s  = push && pop && nonempty_s;
  assign top        = nonempty_s ? mem_r[top_idx_s] : 32'h0000_0000;
  assign count      = count_r;

  // Pointer and occupancy; a replace leaves both unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r   <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
    end else if (replace_s) begin
      ptr_r   <= ptr_r;
      count_r <= count_r;
    end else if (push) begin
      ptr_r <= ptr_r + PW'(1'b1);
      if (count_r != FULL) begin
        count_r <= count_r + CW'(1'b1);
      end
    end else if (pop && nonempty_s) begin
      ptr_r   <= ptr_r - PW'(1'b1);
      count_r <= count_r - CW'(1'b1);
    end
  end

  // Entry storage; contents are don't-care while count says empty.
  always_ff @(posedge clk) begin
    if (replace_s) begin
      mem_r[top_idx_s] <= push_data;
    end else if (push) begin
      mem_r[ptr_r] <= push_data;
    end
  end

endmodule

// File: rtl/f_pc_unit.sv
// f_pc_unit: fetch-stage PC register and next-PC selection (one delay slot).
// Ports:
//  clk, reset   clock, asynchronous active-high reset
//  bus          f_pc_unit_if.slave:
//                 in : stall, exc_req, eret_req, epc, npc_sel, pc4_d, i16,
//                      i26, b_jump, rs_d, call_d, ret_d
//                 out: pc_f, npc (combinational), pc_adel_f (combinational),
//                      ras_top, ras_empty, ras_hit, ras_miss
// Redirect priority: exception, eret, stall hold, j/jal, taken branch,
// jr/jalr, sequential. A return-address stack shadows jal/jr pairs and
// counts how often the predicted return matched the real target.
module f_pc_unit
  import f_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = RESET_PC,
  parameter logic [31:0] EXC_ADDR   = EXC_PC,
  parameter int          IMEM_BYTES = 16384,
  parameter int          RAS_DEPTH  = 4,
  parameter int          CNT_W      = 16
) (
  input logic          clk,
  input logic          reset,
  f_pc_unit_if.slave   bus
);

  localparam logic [32:0] PC_END = {1'b0, RESET_ADDR} + 33'(IMEM_BYTES);

  logic [31:0]              pc_r;
  logic [31:0]              npc_s;
  logic [31:0]              pc_d_s;
  logic [31:0]              seq_s;
  logic                     upd_s;
  logic                     push_s;
  logic                     pop_s;
  logic [31:0]              top_s;
  logic [$clog2(RAS_DEPTH):0] count_s;
  logic                     empty_s;
  logic                     hit_s;
  logic                     miss_s;
  logic [CNT_W-1:0]         hit_r;
  logic [CNT_W-1:0]         miss_r;

  assign pc_d_s = bus.pc4_d - 32'd4;
  assign seq_s  = pc_r + 32'd4;

  // Next-PC priority mux.
  always_comb begin
    npc_s = seq_s;
    if (bus.exc_req) begin
      npc_s = EXC_ADDR;
    end else if (bus.eret_req) begin
      npc_s = bus.epc;
    end else if (bus.stall) begin
      npc_s = pc_r;
    end else begin
      case (bus.npc_sel)
        NPC_J:   npc_s = {pc_d_s[31:28], bus.i26, 2'b00};
        NPC_BR:  npc_s = bus.b_jump ? (pc_d_s + 32'd4 + br_offset(bus.i16)) : seq_s;
        NPC_JR:  npc_s = bus.rs_d;
        default: npc_s = seq_s;
      endcase
    end
  end

  // Fetch PC register; it follows npc even on an address error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r <= RESET_ADDR;
    end else begin
      pc_r <= npc_s;
    end
  end

  // Stack traffic only when D actually advances and no redirect is in M.
  assign upd_s  = !bus.stall && !bus.exc_req && !bus.eret_req;
  assign push_s = upd_s && bus.call_d;
  assign pop_s  = upd_s && bus.ret_d;

  f_pc_unit_ras_stack #(
    .DEPTH (RAS_DEPTH)
  ) u_ras_stack (
    .clk       (clk),
    .rst       (reset),
    .push      (push_s),
    .pop       (pop_s),
    .push_data (bus.pc4_d + 32'd4),
    .top       (top_s),
    .count     (count_s)
  );

  assign empty_s = (count_s == '0);
  // The compare always sees the pre-update top, even if a push lands too.
  assign hit_s   = pop_s && !empty_s && (bus.rs_d == top_s);
  assign miss_s  = pop_s && !hit_s;

  // Saturating prediction statistics.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_r  <= {CNT_W{1'b0}};
      miss_r <= {CNT_W{1'b0}};
    end else begin
      if (hit_s && (hit_r != {CNT_W{1'b1}})) begin
        hit_r <= hit_r + CNT_W'(1'b1);
      end
      if (miss_s && (miss_r != {CNT_W{1'b1}})) begin
        miss_r <= miss_r + CNT_W'(1'b1);
      end
    end
  end

  assign bus.pc_f      = pc_r;
  assign bus.npc       = npc_s;
  assign bus.pc_adel_f = (pc_r[1:0] != 2'b00) ||
                         (pc_r < RESET_ADDR) ||
                         ({1'b0, pc_r} >= PC_END);
  assign bus.ras_top   = top_s;
  assign bus.ras_empty = empty_s;
  assign bus.ras_hit   = hit_r;
  assign bus.ras_miss  = miss_r;

endmodule
